// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: stores strobed bytes in a circular FIFO and
// presents them first-word-fall-through on a valid/ready port, with sticky overrun.
module uart_rx_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overrun,
  input  logic              clr_overrun
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          empty_reg, full_reg, afull_reg, valid_reg;
  logic          overrun_reg, overrun_next;
  logic          push, pop, drop;

  // A pop in the same cycle frees the slot, so a write into a full FIFO is accepted.
  always_comb begin
    pop  = valid_reg & m_ready;
    push = rx_done & (~full_reg | pop);
    drop = rx_done & full_reg & ~pop;
  end

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    overrun_next = overrun_reg;
    if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
    if (push && !pop)      count_next = count_reg + CW'(1);
    else if (pop && !push) count_next = count_reg - CW'(1);
    if (drop)             overrun_next = 1'b1;
    else if (clr_overrun) overrun_next = 1'b0;
  end

  // Status flags are registered from the next-state count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      empty_reg   <= 1'b1;
      full_reg    <= 1'b0;
      afull_reg   <= 1'b0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      empty_reg   <= (count_next == '0);
      full_reg    <= (count_next == CW'(DEPTH));
      afull_reg   <= (count_next >= CW'(AFULL_THRESH));
      valid_reg   <= (count_next != '0);
      overrun_reg <= overrun_next;
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= rx_data;
  end

  assign m_data      = valid_reg ? mem[rd_ptr_reg] : '0;
  assign m_valid     = valid_reg;
  assign count       = count_reg;
  assign empty       = empty_reg;
  assign full        = full_reg;
  assign almost_full = afull_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the FIFO rules.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 12;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              overrun;
  logic              clr_overrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_q[$];
  bit         model_ovr;

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    check_eq({tag, ".count"},   32'(count), 32'(n));
    check_eq({tag, ".m_valid"}, 32'(m_valid), 32'(n != 0));
    check_eq({tag, ".m_data"},  32'(m_data), (n != 0) ? 32'(model_q[0]) : 32'h0);
    check_eq({tag, ".empty"},   32'(empty), 32'(n == 0));
    check_eq({tag, ".full"},    32'(full), 32'(n == DEPTH));
    check_eq({tag, ".afull"},   32'(almost_full), 32'(n >= AFULL));
    check_eq({tag, ".overrun"}, 32'(overrun), 32'(model_ovr));
  endtask

  // One clock: apply inputs, advance the model by one edge, compare everything.
  task automatic step(input string tag, input bit d, input logic [7:0] b,
                      input bit r, input bit c);
    bit do_pop, do_push, is_full;
    rx_done = d; rx_data = b; m_ready = r; clr_overrun = c;
    do_pop  = (model_q.size() > 0) && r;
    is_full = (model_q.size() == DEPTH);
    do_push = d && (!is_full || do_pop);
    @(posedge clk);
    #1;
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(b);
    if (d && is_full && !do_pop) model_ovr = 1'b1;
    else if (c)                  model_ovr = 1'b0;
    $display("[%0t] %s rx_done=%0b data=%02h ready=%0b clr=%0b -> count=%0d m_valid=%0b m_data=%02h ovr=%0b",
             $time, tag, d, b, r, c, count, m_valid, m_data, overrun);
    check_all(tag);
    rx_done = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; rx_data = '0; m_ready = 1'b0; clr_overrun = 1'b0;
    model_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single byte in and out
    step("c1_wr",  1, 8'h37, 0, 0);
    step("c1_rd",  0, 8'h00, 1, 0);
    step("c1_idl", 0, 8'h00, 1, 0);

    // 2: ordering with held head
    step("c2_wr0", 1, 8'h37, 0, 0);
    step("c2_wr1", 1, 8'hA5, 0, 0);
    step("c2_hld", 0, 8'h00, 0, 0);
    step("c2_rd0", 0, 8'h00, 1, 0);
    step("c2_rd1", 0, 8'h00, 1, 0);

    // 3: fill, overrun drop, drain
    for (int i = 0; i < DEPTH; i++) step("c3_fill", 1, 8'(i), 0, 0);
    step("c3_drop", 1, 8'hEE, 0, 0);
    for (int i = 0; i < DEPTH; i++) step("c3_drain", 0, 8'h00, 1, 0);
    step("c5_clr", 0, 8'h00, 0, 1);

    // 4: full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step("c4_fill", 1, 8'(8'h80 + i), 0, 0);
    step("c4_both", 1, 8'h55, 1, 0);
    // 5: set beats clear when a drop coincides with clr_overrun
    step("c5_drop", 1, 8'h11, 0, 0);
    step("c5_both", 1, 8'h22, 0, 1);
    step("c5_clr2", 0, 8'h00, 0, 1);
    for (int i = 0; i < DEPTH; i++) step("c4_drain", 0, 8'h00, 1, 0);

    // empty + rx_done + m_ready: push only
    step("e_both", 1, 8'h66, 1, 0);
    step("e_rd",   0, 8'h00, 1, 0);

    // 6: wrap pointers then reset at count=5
    for (int i = 0; i < 5; i++) step("c6_pre", 1, 8'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 40; i++) step("c6_pair", 1, 8'($urandom_range(0, 255)), 1, 0);
    step("c6_drop_prep", 0, 8'h00, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    model_ovr = 1'b0;
    check_all("c6_async_rst");
    @(posedge clk); #3 rst_n = 1'b1;
    step("c6_wr", 1, 8'h5A, 0, 0);
    step("c6_rd", 0, 8'h00, 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
